// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch sequencer.
//   fetch_state_e  : sequencer state encoding
//   PC_INC_DEFAULT : sequential PC step (word addressing)
//   RESET_VEC      : PC value loaded by reset
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_FLUSH,
    ST_HALT
  } fetch_state_e;

  localparam int unsigned PC_INC_DEFAULT = 1;
  localparam logic [15:0] RESET_VEC      = 16'h0000;

endpackage

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer of the 16-bit RISC core.
// Computes the next PC and its write enable, fetches one instruction per PC
// value over a req/ack memory handshake and presents it to decode over a
// valid/ready handshake. Taken branches from execute squash the in-flight
// instruction.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   pc_cur           current PC register value
//   pc_next          value to load into the PC register
//   pc_wrt_s2        single-cycle PC write enable
//   imem_req         fetch request, held until imem_ack
//   imem_addr        fetch address, stable while imem_req=1
//   imem_ack         memory returns imem_rdata this cycle
//   imem_rdata       instruction word
//   ir_valid         ir_data holds a deliverable instruction
//   ir_data          instruction to decode
//   ir_ready         decode accepts ir_data this cycle
//   br_taken         execute redirect pulse
//   br_target        redirect address
//   halt             stop fetching (sampled in IDLE and at the HOLD handoff)
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned PC_INC = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_wrt_s2,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              ir_valid,
  output logic [15:0]       ir_data,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] addr_q;

  // Sequential successor; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_INC);
  endfunction

  // In REQ the address follows pc_cur directly: the PC has always been
  // updated by the time REQ is entered (HOLD and the branch IDLE cycle give
  // the PC register its write cycle). FLUSH replays the captured address so
  // an outstanding request never changes under the memory.
  always_comb begin
    imem_addr = '0;
    if (state == ST_REQ)
      imem_addr = pc_cur;
    else if (state == ST_FLUSH)
      imem_addr = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc_next   <= ADDR_W'(RESET_VEC);
      pc_wrt_s2 <= 1'b0;
      imem_req  <= 1'b0;
      ir_valid  <= 1'b0;
      ir_data   <= '0;
      addr_q    <= ADDR_W'(RESET_VEC);
    end else begin
      pc_wrt_s2 <= 1'b0;
      if (state == ST_REQ)
        addr_q <= pc_cur;

      case (state)
        ST_IDLE: begin
          if (br_taken) begin
            pc_next   <= br_target;
            pc_wrt_s2 <= 1'b1;
          end else if (halt) begin
            state <= ST_HALT;
          end else begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end

        ST_REQ: begin
          if (br_taken) begin
            // Branch beats ack: acked data (if any) is dropped.
            pc_next   <= br_target;
            pc_wrt_s2 <= 1'b1;
            if (imem_ack) begin
              state    <= ST_IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= ST_FLUSH;
            end
          end else if (imem_ack) begin
            ir_data   <= imem_rdata;
            pc_next   <= pc_incr(pc_cur);
            pc_wrt_s2 <= 1'b1;
            imem_req  <= 1'b0;
            ir_valid  <= 1'b1;
            state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (br_taken) begin
            pc_next   <= br_target;
            pc_wrt_s2 <= 1'b1;
            ir_valid  <= 1'b0;
            state     <= ST_IDLE;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            if (halt) begin
              state <= ST_HALT;
            end else begin
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          if (br_taken) begin
            pc_next   <= br_target;
            pc_wrt_s2 <= 1'b1;
          end
          if (imem_ack) begin
            state    <= ST_IDLE;
            imem_req <= 1'b0;
          end
        end

        ST_HALT: begin
          // Only reset leaves HALT.
        end

        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        pc_wrt_s2;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic        ir_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt;

  // bench-side models
  logic [15:0] pc_q;
  logic        pc_ovr;
  logic [15:0] pc_ovr_val;
  int          ack_dly;
  int          req_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk       (clk),
    .rst       (rst),
    .pc_cur    (pc_cur),
    .pc_next   (pc_next),
    .pc_wrt_s2 (pc_wrt_s2),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir_valid  (ir_valid),
    .ir_data   (ir_data),
    .ir_ready  (ir_ready),
    .br_taken  (br_taken),
    .br_target (br_target),
    .halt      (halt)
  );

  // PC register
  always @(posedge clk) begin
    if (rst)
      pc_q <= 16'h0000;
    else if (pc_ovr)
      pc_q <= pc_ovr_val;
    else if (pc_wrt_s2)
      pc_q <= pc_next;
  end
  assign pc_cur = pc_q;

  // Instruction memory: ack after ack_dly cycles of continuous request.
  always @(posedge clk) begin
    if (rst || !imem_req)
      req_cnt <= 0;
    else
      req_cnt <= req_cnt + 1;
  end
  assign imem_ack   = imem_req && (req_cnt == ack_dly);
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; br_target = 16'h0000;
    halt = 1'b0; pc_ovr = 1'b0; pc_ovr_val = 16'h0000; ack_dly = 0;
    tick(); tick();
    check("rst_req",    imem_req,  0);
    check("rst_wrt",    pc_wrt_s2, 0);
    check("rst_valid",  ir_valid,  0);
    check("rst_pcnext", pc_next,   0);
    check("rst_irdata", ir_data,   0);
    check("rst_addr",   imem_addr, 0);

    rst = 1'b0;
    tick();  // IDLE -> REQ
    // Sequential fetches with 1-cycle ack
    for (int i = 0; i < 3; i++) begin
      check("seq_req",  imem_req,  1);
      check("seq_addr", imem_addr, i);
      check("seq_wrt0", pc_wrt_s2, 0);
      tick();
      check("seq_valid",  ir_valid,  1);
      check("seq_irdata", ir_data,   16'(i) ^ 16'hA5A5);
      check("seq_wrt",    pc_wrt_s2, 1);
      check("seq_pcnext", pc_next,   i + 1);
      check("seq_reqlo",  imem_req,  0);
      tick();
    end

    // Decode stalls for 5 cycles in HOLD
    check("stall_addr", imem_addr, 3);
    ir_ready = 1'b0;
    tick();
    check("stall_pcnext", pc_next, 4);
    check("stall_wrt",    pc_wrt_s2, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid",  ir_valid,  1);
      check("stall_irdata", ir_data,   16'hA5A6);
      check("stall_req",    imem_req,  0);
      check("stall_wrt0",   pc_wrt_s2, 0);
    end
    ack_dly  = 3;
    ir_ready = 1'b1;
    tick();

    // Branch in REQ with ack delayed 3 cycles
    check("br_req_addr", imem_addr, 4);
    br_taken = 1'b1; br_target = 16'h0040;
    tick();
    br_taken = 1'b0;
    check("br_wrt",    pc_wrt_s2, 1);
    check("br_pcnext", pc_next,   16'h0040);
    check("br_fl_req", imem_req,  1);
    check("br_fl_addr", imem_addr, 4);
    tick();
    check("br_fl_addr2", imem_addr, 4);
    check("br_fl_wrt0",  pc_wrt_s2, 0);
    tick();
    check("br_fl_ack",   imem_ack,  1);
    check("br_fl_addr3", imem_addr, 4);
    check("br_fl_valid", ir_valid,  0);
    tick();
    check("br_idle_req",   imem_req, 0);
    check("br_idle_valid", ir_valid, 0);
    tick();
    check("br_new_req",  imem_req,  1);
    check("br_new_addr", imem_addr, 16'h0040);

    // Branch coinciding with ack in REQ
    ack_dly  = 0;
    br_taken = 1'b1; br_target = 16'h0100;
    tick();
    br_taken = 1'b0;
    check("brack_wrt",    pc_wrt_s2, 1);
    check("brack_pcnext", pc_next,   16'h0100);
    check("brack_valid",  ir_valid,  0);
    check("brack_req",    imem_req,  0);
    tick();
    check("brack_valid2", ir_valid,  0);
    check("brack_addr",   imem_addr, 16'h0100);
    tick();
    check("brack_irdata", ir_data,   16'h0100 ^ 16'hA5A5);
    check("brack_pcnext2", pc_next,  16'h0101);

    // PC wrap at FFFF, then halt at the HOLD handoff
    pc_ovr = 1'b1; pc_ovr_val = 16'hFFFF;
    tick();
    pc_ovr = 1'b0;
    check("wrap_addr", imem_addr, 16'hFFFF);
    halt = 1'b1;
    tick();
    check("wrap_pcnext", pc_next,   16'h0000);
    check("wrap_wrt",    pc_wrt_s2, 1);
    check("wrap_irdata", ir_data,   16'h5A5A);
    tick();
    check("halt_req",   imem_req,  0);
    check("halt_valid", ir_valid,  0);
    br_taken = 1'b1; br_target = 16'h1234;
    tick();
    br_taken = 1'b0;
    check("halt_br_wrt", pc_wrt_s2, 0);
    check("halt_br_req", imem_req,  0);
    tick(); tick();
    check("halt_req2", imem_req, 0);

    rst = 1'b1; halt = 1'b0;
    tick();
    rst = 1'b0;
    check("rst2_req", imem_req, 0);
    tick();
    check("rst2_req1", imem_req,  1);
    check("rst2_addr", imem_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that drives the write side of the program-counter register: it computes the next PC value and the PC write-enable. It fetches one 16-bit instruction per PC value from instruction memory through a req/ack handshake and hands it to decode through a valid/ready handshake. Taken-branch redirects from execute squash the in-flight instruction. It sits between the PC register, instruction memory and the decode stage of the 16-bit RISC core.

## Interface
- `ADDR_W`, default 16: PC/address width.
- `PC_INC`, default 1: sequential PC increment (word addressing).
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_cur`  in  16  current PC value, read from the PC register output.
- `pc_next`  out  16  value to load into the PC; drives the PC data input.
- `pc_wrt_s2`  out  1  PC write enable; a single-cycle pulse per update.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  16  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory has returned `imem_rdata` this cycle.
- `imem_rdata`  in  16  instruction word.
- `ir_valid`  out  1  `ir_data` holds a valid instruction.
- `ir_data`  out  16  instruction to decode.
- `ir_ready`  in  1  decode accepts `ir_data` this cycle.
- `br_taken`  in  1  execute redirect; single-cycle pulse.
- `br_target`  in  16  redirect address, qualified by `br_taken`.
- `halt`  in  1  stop fetching; sampled only at fetch-issue points.

## Operation
- States: IDLE, REQ, HOLD, FLUSH, HALT.
- IDLE: if `halt`=1, go to HALT; otherwise go to REQ.
- REQ: `imem_req`=1 and `imem_addr`=`pc_cur`; `addr_q` captures `pc_cur` every REQ cycle.
  - On `imem_ack` with no branch: `ir_data`<=`imem_rdata`; `pc_next`<=`pc_cur`+`PC_INC` (modulo 2^16, so FFFF wraps to 0000); `pc_wrt_s2`<=1; go to HOLD.
- HOLD: `ir_valid`=1.
  - On `ir_ready`: if `halt`=1, go to HALT; otherwise go to REQ.
- FLUSH: `imem_req`=1 and `imem_addr`=`addr_q`. A request is never withdrawn before its ack.
  - On `imem_ack`: discard the data and go to IDLE.
- HALT: all outputs idle. Only `rst` exits HALT; `br_taken` is ignored.
- Branch handling (`br_taken`=1) in IDLE, REQ, HOLD or FLUSH: `pc_next`<=`br_target`, `pc_wrt_s2`<=1. Branch has priority over ack.
  - In IDLE: stay in IDLE.
  - In REQ without ack: go to FLUSH.
  - In REQ with ack in the same cycle: discard the data and go to IDLE.
  - In HOLD: `ir_valid` drops next cycle and the instruction is not delivered, even if `ir_ready`=1; go to IDLE.
  - In FLUSH: latest target wins; stay in FLUSH, or go to IDLE if ack arrives in the same cycle.
- Reset values: state IDLE; `pc_next`=0000, `pc_wrt_s2`=0, `imem_req`=0, `imem_addr`=0000, `ir_valid`=0, `ir_data`=0000, `addr_q`=0000.
- Reset mid-REQ or mid-FLUSH drops `imem_req` immediately. Instruction memory is reset in the same cycle.

## Timing
- `pc_next` and `pc_wrt_s2` are registered: they are asserted in the cycle after the triggering ack or branch, so the PC updates at the end of that cycle.
- HOLD always lasts at least one cycle, and a branch always passes through IDLE. Together these guarantee that `pc_cur` has already been updated whenever REQ is entered.
- Best-case throughput with a 1-cycle ack and `ir_ready` tied high: one instruction every 2 cycles.
- Fetch latency: `imem_req` rises 1 cycle after reset release, since IDLE occupies the first cycle.
- Branch-to-new-request latency: 2 cycles (PC write, then IDLE), plus the remaining ack wait when the branch lands in FLUSH.
- `ir_data` is stable while `ir_valid`=1.

## Structure
- Package `fetch_pkg`: state enum, `PC_INC`, reset vector constant 16'h0000.
- Single module. No sub-module: the FSM plus three registers (`addr_q`, `ir_data`, `pc_next`) does not justify a split.

## Test plan
- Reset, then 1-cycle ack with `ir_ready`=1 and `pc_cur` modelled as a PC register: fetches from 0000, 0001, 0002 in order; `pc_wrt_s2` pulses once per fetch with `pc_next`=0001, 0002, 0003.
- `ir_ready`=0 for 5 cycles in HOLD: `ir_valid` and `ir_data` are held; no new `imem_req`; no further `pc_wrt_s2` after the first pulse.
- `br_taken`, target 0040, during REQ with ack delayed 3 cycles: `pc_next`=0040 pulses; `imem_addr` stays at the old address until ack; the data is discarded (`ir_valid` stays 0); the next request goes to 0040.
- `br_taken` with target 0100 and `imem_ack` in the same REQ cycle: the acked data is never presented, and the next fetch is at 0100.
- `pc_cur`=FFFF fetch: `pc_next`=0000. Then `halt`=1 at the HOLD handoff: state is HALT, no further requests, a later `br_taken` is ignored, and `rst` restarts fetch at 0000.
